// File: rtl/gray_to_bin_sync.sv
// Gray pointer receiver: synchronizes a cross-domain Gray pointer, decodes it to binary, flags +1 steps and illegal jumps.
// Latency: SYNC_STAGES+1 clocks from gray_data_i to bin_data_o / inc_o / step_err_o.
// Backpressure: none; a new sample is accepted every clock.
//
// Ports:
//   clk, rst_n   single rising-edge clock, async active-low reset
//   gray_data_i  Gray pointer from the other domain (may be asynchronous)
//   err_clr_i    synchronous clear of the sticky step error
//   bin_data_o   registered binary pointer
//   bin_vld_o    pipeline warmed up since the last reset
//   inc_o        one-cycle pulse when the pointer advanced by exactly +1
//   step_err_o   sticky flag, set by a multi-bit Gray change
module gray_to_bin_sync #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH:0]   gray_data_i,
    input  logic             err_clr_i,
    output logic [WIDTH:0]   bin_data_o,
    output logic             bin_vld_o,
    output logic             inc_o,
    output logic             step_err_o
);

    localparam int PW = WIDTH + 1;
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_VLD = CW'(SYNC_STAGES);

    // Synchronizer chain: plain flops, nothing between stages.
    logic [PW-1:0] s_q [SYNC_STAGES];
    logic [PW-1:0] g_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                s_q[i] <= '0;
            end
        end else begin
            s_q[0] <= gray_data_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                s_q[i] <= s_q[i-1];
            end
        end
    end

    assign g_s = s_q[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
    logic [PW-1:0] bin_d;
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < PW; i++) begin
            bin_d[i] = ^(g_s >> i);
        end
    end

    // Warm-up counter saturates at SYNC_STAGES+1; valid latches on the edge
    // where the first post-reset sample reaches the decode register.
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        vld_d = vld_q | (cnt_q == CNT_VLD);
    end

    // Step check against the previous synchronized sample. Only trusted once
    // valid, so the flush to zero after reset never reads as a jump.
    logic [PW-1:0] g_prev_q;
    logic [PW-1:0] diff;
    logic          multi_bit;

    assign diff      = g_s ^ g_prev_q;
    assign multi_bit = (diff & (diff - ONE)) != '0;

    logic [PW-1:0] bin_q;
    logic          inc_q, inc_d;
    logic          err_q, err_d;

    always_comb begin
        // bin_q is the decode of g_prev_q, so comparing against bin_q+1 gives
        // the +1 test with natural modulo wrap.
        inc_d = vld_q && (bin_d == bin_q + ONE);
        err_d = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        // Set has priority over a simultaneous clear.
        if (vld_q && multi_bit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            g_prev_q <= '0;
            bin_q    <= '0;
            inc_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            g_prev_q <= g_s;
            bin_q    <= bin_d;
            inc_q    <= inc_d;
            err_q    <= err_d;
        end
    end

    assign bin_data_o = bin_q;
    assign bin_vld_o  = vld_q;
    assign inc_o      = inc_q;
    assign step_err_o = err_q;

endmodule

// File: tb/tb_gray_to_bin_sync.sv
module tb_gray_to_bin_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] gray_data_i;
    logic       err_clr_i;
    logic [5:0] bin_data_o;
    logic       bin_vld_o;
    logic       inc_o;
    logic       step_err_o;

    int total = 0;
    int bad   = 0;

    gray_to_bin_sync #(.WIDTH(5), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gray_data_i (gray_data_i),
        .err_clr_i   (err_clr_i),
        .bin_data_o  (bin_data_o),
        .bin_vld_o   (bin_vld_o),
        .inc_o       (inc_o),
        .step_err_o  (step_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] to_gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive one Gray value, check the old value still shows two clocks in,
    // the new value and inc on the third, and that inc is a single pulse.
    task automatic step(input string tag, input logic [5:0] g, input logic [5:0] old_b,
                        input logic [5:0] new_b, input logic exp_inc, input logic exp_err);
        gray_data_i = g;
        tick();
        tick();
        chk({tag, "_hold"}, bin_data_o, old_b);
        tick();
        chk({tag, "_bin"}, bin_data_o, new_b);
        chk({tag, "_inc"}, inc_o, exp_inc);
        chk({tag, "_err"}, step_err_o, exp_err);
        tick();
        chk({tag, "_inc_off"}, inc_o, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        gray_data_i = 6'd0;
        err_clr_i   = 1'b0;

        // 1. Reset state and warm-up
        #2;
        chk("rst_bin", bin_data_o, 0);
        chk("rst_vld", bin_vld_o, 0);
        chk("rst_inc", inc_o, 0);
        chk("rst_err", step_err_o, 0);
        #21 rst_n = 1'b1;           // released between edges
        tick();
        chk("warm_e1_vld", bin_vld_o, 0);
        tick();
        chk("warm_e2_vld", bin_vld_o, 0);
        tick();
        chk("warm_e3_vld", bin_vld_o, 1);
        chk("warm_bin", bin_data_o, 0);
        chk("warm_inc", inc_o, 0);
        chk("warm_err", step_err_o, 0);
        tick();
        chk("const_inc", inc_o, 0);
        chk("const_vld", bin_vld_o, 1);

        // 2. Full forward sequence 1..63
        for (int k = 1; k < 64; k++) begin
            step("seq", to_gray(6'(k)), 6'(k - 1), 6'(k), 1'b1, 1'b0);
        end

        // 3. Wrap 63 (gray 100000) -> 0
        step("wrap", 6'b000000, 6'd63, 6'd0, 1'b1, 1'b0);

        // 4. Illegal jump, sticky, clear, and set-beats-clear
        step("j_pre", 6'b000001, 6'd0, 6'd1, 1'b1, 1'b0);
        step("jump", 6'b000110, 6'd1, 6'd4, 1'b0, 1'b1);
        tick();
        tick();
        chk("sticky", step_err_o, 1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("clr", step_err_o, 0);
        gray_data_i = 6'b000000;    // 2-bit change, illegal
        tick();
        tick();
        err_clr_i = 1'b1;           // clear lands on the same edge as the set
        tick();
        err_clr_i = 1'b0;
        chk("set_wins", step_err_o, 1);
        chk("set_wins_bin", bin_data_o, 0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("clr2", step_err_o, 0);

        // 5. Backward step 2 -> 1
        step("b_pre1", 6'b000001, 6'd0, 6'd1, 1'b1, 1'b0);
        step("b_pre2", 6'b000011, 6'd1, 6'd2, 1'b1, 1'b0);
        step("back", 6'b000001, 6'd2, 6'd1, 1'b0, 1'b0);

        // 6. Async reset mid-operation
        step("r_pre", 6'b000011, 6'd1, 6'd2, 1'b1, 1'b0);
        gray_data_i = 6'b000111;    // in flight when reset hits
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_bin", bin_data_o, 0);
        chk("mrst_vld", bin_vld_o, 0);
        chk("mrst_inc", inc_o, 0);
        chk("mrst_err", step_err_o, 0);
        gray_data_i = 6'b000011;
        #3 rst_n = 1'b1;
        tick();
        chk("rw_e1_vld", bin_vld_o, 0);
        tick();
        chk("rw_e2_vld", bin_vld_o, 0);
        chk("rw_e2_bin", bin_data_o, 0);
        tick();
        chk("rw_e3_vld", bin_vld_o, 1);
        chk("rw_e3_bin", bin_data_o, 2);
        chk("rw_e3_inc", inc_o, 0);
        chk("rw_e3_err", step_err_o, 0);
        tick();
        chk("rw_inc", inc_o, 0);
        chk("rw_err", step_err_o, 0);
        // Single-bit Gray change that is not +1 (2 -> 5): no inc, no error
        step("skip", 6'b000111, 6'd2, 6'd5, 1'b0, 1'b0);
        step("resume", 6'b000110, 6'd5, 6'd4, 1'b0, 1'b0);
        step("resume2", 6'b000111, 6'd4, 6'd5, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
